// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the instruction cache
// (line-fill reads) and the data cache (line fills and write-backs). Arbitration
// is round-robin and only one memory transaction is ever outstanding.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   grant_valid;
    logic   grant_sel;

    assign busy = (state != IDLE);

    // Arbitration and next state: in IDLE pick a requester, favouring the side not served last on a tie.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_valid = 1'b1;
                    grant_sel   = ~last_grant;
                end else if (i_req) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b0;
                end else if (d_req) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b1;
                end
                if (grant_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory port, grant bookkeeping, ready pulses and captured fill data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (state == IDLE && grant_valid) begin
                mem_req    <= 1'b1;
                mem_we     <= grant_sel ? d_we : 1'b0;
                mem_addr   <= grant_sel ? d_addr : i_addr;
                mem_wdata  <= grant_sel ? d_wdata : '0;
                owner      <= grant_sel;
                last_grant <= grant_sel;
            end
            if (state == BUSY && mem_ready) begin
                mem_req <= 1'b0;
                if (owner) begin
                    d_ready <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end else begin
                    i_ready <= 1'b1;
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives the arbiter with cache requester models and a memory
// model, and compares every cycle against a transaction-level reference.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } dtxn_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [LW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          d_ready;
    logic [LW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;
    logic          owner;

    // Comparison bookkeeping.
    int checks = 0;
    int passes = 0;

    // Requester work lists: each entry becomes one request on the cache side.
    logic [AW-1:0] iq[$];
    dtxn_t         dq[$];
    dtxn_t         rtx;

    // Memory model controls.
    int            mem_count = -1;
    int            fixed_lat = -1;
    bit            fixed_data_en = 1'b0;
    logic [LW-1:0] fixed_data = '0;
    bit            spur_en = 1'b0;
    bit            force_spur = 1'b0;

    // Observation records.
    int cyc = 0;
    int i_raise_cyc = 0;
    int i_ready_cyc = 0;
    int i_ready_cnt = 0;
    int d_ready_cnt = 0;
    bit prev_mem_req = 1'b0;
    bit grant_seq[$];
    bit exp4[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reference: one open transaction at most, then a single response cycle.
    bit            m_open;
    bit            m_resp;
    bit            m_last;
    bit            m_owner;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_irdata;
    logic [LW-1:0] m_drdata;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .owner     (owner)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the inputs the DUT just sampled.
    task automatic modelUpdate();
        bit was_resp;
        was_resp = m_resp;
        m_resp   = 1'b0;
        if (m_open) begin
            if (mem_ready) begin
                m_open = 1'b0;
                m_resp = 1'b1;
                if (!m_we) begin
                    if (m_owner) m_drdata = mem_rdata;
                    else         m_irdata = mem_rdata;
                end
            end
        end else if (!was_resp && (i_req || d_req)) begin
            m_owner = (i_req && d_req) ? ~m_last : d_req;
            m_last  = m_owner;
            m_open  = 1'b1;
            m_we    = m_owner ? d_we : 1'b0;
            m_addr  = m_owner ? d_addr : i_addr;
            m_wdata = m_owner ? d_wdata : '0;
        end
    endtask

    // Compare all DUT outputs against the reference for the current cycle.
    task automatic checkCycle();
        checkOutput("mem_req", LW'(mem_req), LW'(m_open));
        checkOutput("busy", LW'(busy), LW'(m_open || m_resp));
        checkOutput("i_ready", LW'(i_ready), LW'(m_resp && !m_owner));
        checkOutput("d_ready", LW'(d_ready), LW'(m_resp && m_owner));
        checkOutput("owner", LW'(owner), LW'(m_owner));
        if (m_open) begin
            checkOutput("mem_we", LW'(mem_we), LW'(m_we));
            checkOutput("mem_addr", LW'(mem_addr), LW'(m_addr));
            checkOutput("mem_wdata", mem_wdata, m_wdata);
        end
        checkOutput("i_rdata", i_rdata, m_irdata);
        checkOutput("d_rdata", d_rdata, m_drdata);
    endtask

    // Requesters hold req until ready, then drop it or move straight to their next entry; memory answers after a latency.
    task automatic applyStimulus();
        if (i_req && i_ready) begin
            if (iq.size() > 0) i_addr = iq.pop_front();
            else               i_req  = 1'b0;
        end else if (!i_req && iq.size() > 0) begin
            i_addr      = iq.pop_front();
            i_req       = 1'b1;
            i_raise_cyc = cyc;
        end
        if (d_req && d_ready) begin
            if (dq.size() > 0) begin
                rtx     = dq.pop_front();
                d_we    = rtx.we;
                d_addr  = rtx.addr;
                d_wdata = rtx.wdata;
            end else begin
                d_req = 1'b0;
            end
        end else if (!d_req && dq.size() > 0) begin
            rtx     = dq.pop_front();
            d_we    = rtx.we;
            d_addr  = rtx.addr;
            d_wdata = rtx.wdata;
            d_req   = 1'b1;
        end
        mem_ready = 1'b0;
        mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (mem_req) begin
            if (mem_count < 0) mem_count = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 6));
            if (mem_count == 0) begin
                mem_ready = 1'b1;
                if (fixed_data_en) mem_rdata = fixed_data;
                mem_count = -1;
            end else begin
                mem_count--;
            end
        end else begin
            mem_count = -1;
            if (force_spur || (spur_en && $urandom_range(0, 7) == 0)) mem_ready = 1'b1;
            force_spur = 1'b0;
        end
    endtask

    // One clock: sample just after the edge, check, record, then drive the next inputs.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
        modelUpdate();
        checkCycle();
        if (mem_req && !prev_mem_req) grant_seq.push_back(owner);
        prev_mem_req = mem_req;
        if (i_ready) begin
            i_ready_cnt++;
            i_ready_cyc = cyc;
        end
        if (d_ready) d_ready_cnt++;
        applyStimulus();
    endtask

    // Run until both work lists are served and the arbiter is idle, within a cycle budget.
    task automatic runUntilIdle(input string tag, input int bound);
        int n;
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (n < bound && (iq.size() > 0 || dq.size() > 0 || i_req || d_req || busy));
        checkOutput({tag, "_drained"}, LW'(busy || i_req || d_req), '0);
    endtask

    // Hold reset across two edges, check the cleared outputs and restart the reference.
    task automatic doReset();
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        iq.delete(); dq.delete();
        mem_count = -1; force_spur = 1'b0; prev_mem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mem_req", LW'(mem_req), '0);
        checkOutput("rst_mem_we", LW'(mem_we), '0);
        checkOutput("rst_mem_addr", LW'(mem_addr), '0);
        checkOutput("rst_mem_wdata", mem_wdata, '0);
        checkOutput("rst_i_ready", LW'(i_ready), '0);
        checkOutput("rst_d_ready", LW'(d_ready), '0);
        checkOutput("rst_i_rdata", i_rdata, '0);
        checkOutput("rst_d_rdata", d_rdata, '0);
        checkOutput("rst_busy", LW'(busy), '0);
        checkOutput("rst_owner", LW'(owner), '0);
        m_open = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_owner = 1'b0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
        rst = 1'b0;
    endtask

    // Directed scenarios first, then a long randomized run.
    initial begin
        doReset();

        fixed_lat     = 5;
        fixed_data_en = 1'b1;
        fixed_data    = 128'hDEADBEEF000000010000000200000003;
        i_ready_cyc   = -100;
        iq.push_back(32'h0000_0800);
        runUntilIdle("tp1", 40);
        checkOutput("tp1_latency", LW'(i_ready_cyc - i_raise_cyc), LW'(7));
        checkOutput("tp1_i_rdata", i_rdata, 128'hDEADBEEF000000010000000200000003);
        checkOutput("tp1_owner", LW'(owner), '0);
        fixed_data_en = 1'b0;

        fixed_lat   = 3;
        d_ready_cnt = 0;
        dq.push_back('{we: 1'b1, addr: 32'h0000_3000, wdata: 128'h1234});
        runUntilIdle("tp2", 40);
        checkOutput("tp2_d_ready_pulses", LW'(d_ready_cnt), LW'(1));
        checkOutput("tp2_d_rdata", d_rdata, '0);

        doReset();
        fixed_lat = -1;
        grant_seq.delete();
        for (int k = 0; k < 2; k++) begin
            iq.push_back($urandom() & 32'hFFFF_FFF0);
            dq.push_back('{we: 1'(k), addr: $urandom() & 32'hFFFF_FFF0, wdata: {$urandom(), $urandom(), $urandom(), $urandom()}});
        end
        runUntilIdle("tp3", 100);
        checkOutput("tp3_grant_count", LW'(grant_seq.size()), LW'(4));
        for (int k = 0; k < 4 && k < grant_seq.size(); k++)
            checkOutput($sformatf("tp3_grant%0d", k), LW'(grant_seq[k]), LW'(k % 2));

        doReset();
        fixed_lat = 2;
        grant_seq.delete();
        for (int k = 0; k < 3; k++)
            dq.push_back('{we: 1'b0, addr: 32'h0000_4000 + 32'(k * 16), wdata: '0});
        for (int k = 0; k < 20 && !(mem_req && owner); k++) stepCycle();
        iq.push_back(32'h0000_1000);
        runUntilIdle("tp4", 100);
        checkOutput("tp4_grant_count", LW'(grant_seq.size()), LW'(4));
        for (int k = 0; k < 4 && k < grant_seq.size(); k++)
            checkOutput($sformatf("tp4_grant%0d", k), LW'(grant_seq[k]), LW'(exp4[k]));

        i_ready_cnt = 0;
        d_ready_cnt = 0;
        force_spur  = 1'b1;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("tp5_busy", LW'(busy), '0);
        checkOutput("tp5_ready_pulses", LW'(i_ready_cnt + d_ready_cnt), '0);

        doReset();
        fixed_lat = 10;
        iq.push_back(32'h0000_2000);
        for (int k = 0; k < 10 && !mem_req; k++) stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("tp6_mem_req_before", LW'(mem_req), LW'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("tp6_mem_req_async", LW'(mem_req), '0);
        checkOutput("tp6_busy_async", LW'(busy), '0);
        checkOutput("tp6_i_ready_async", LW'(i_ready), '0);
        doReset();
        fixed_lat = -1;
        grant_seq.delete();
        iq.push_back(32'h0000_2040);
        dq.push_back('{we: 1'b0, addr: 32'h0000_5000, wdata: '0});
        runUntilIdle("tp6", 60);
        checkOutput("tp6_grant_count", LW'(grant_seq.size()), LW'(2));
        if (grant_seq.size() > 0)
            checkOutput("tp6_first_grant", LW'(grant_seq[0]), '0);

        doReset();
        fixed_lat = -1;
        spur_en   = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (iq.size() < 2 && $urandom_range(0, 3) == 0)
                iq.push_back($urandom() & 32'hFFFF_FFF0);
            if (dq.size() < 2 && $urandom_range(0, 3) == 0) begin
                rtx.we    = 1'($urandom_range(0, 1));
                rtx.addr  = $urandom() & 32'hFFFF_FFF0;
                rtx.wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                dq.push_back(rtx);
            end
            stepCycle();
        end
        spur_en = 1'b0;
        runUntilIdle("rand", 200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the fetch-side instruction cache and the data cache.
- Instruction-cache requests are line-fill reads only. Data-cache requests are line-fill reads or write-backs.
- Round-robin arbitration. Exactly one outstanding memory transaction at a time.
- Sits between the cpu cache controllers and the soc memory model, which answers after MEM_DELAY_CYCLES.

Parameters:
- ADDR_WIDTH, 32, byte address width of requests and of the memory port.
- LINE_WIDTH, 128, cache line width carried on all data buses.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  icache line-fill request; level, held until i_ready.
- i_addr  in  ADDR_WIDTH  icache line address.
- i_ready  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  LINE_WIDTH  registered fill data for icache.
- d_req  in  1  dcache request; level, held until d_ready.
- d_we  in  1  1 = write-back, 0 = line fill.
- d_addr  in  ADDR_WIDTH  dcache line address.
- d_wdata  in  LINE_WIDTH  write-back data.
- d_ready  out  1  one-cycle pulse: transaction done (d_rdata valid if read).
- d_rdata  out  LINE_WIDTH  registered fill data for dcache.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  LINE_WIDTH  memory write data.
- mem_rdata  in  LINE_WIDTH  memory read data; valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse from memory.
- busy  out  1  1 whenever state != IDLE.
- owner  out  1  current/last grantee: 0 = icache, 1 = dcache.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE.
  - i_rdata and d_rdata are cleared to 0.
  - last_grant = 1 (dcache), so icache wins the first tie.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Samples i_req and d_req each edge.
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - Neither high: stay in IDLE.
  - On grant, on the same edge:
    - register mem_addr, mem_we (d_we for dcache, 0 for icache) and mem_wdata (d_wdata for dcache, 0 for icache);
    - set mem_req=1, owner=grantee, last_grant=grantee;
    - go to BUSY.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ready.
  - Requester inputs are ignored.
  - On the mem_ready edge:
    - mem_req=0;
    - for a read, capture mem_rdata into the owner's rdata register;
    - pulse the owner's ready for exactly the next cycle;
    - go to RESP.
- RESP:
  - Ready is high for this single cycle; the requester drops req in this cycle.
  - Next state IDLE.
  - A req still high in IDLE is treated as a new request.
- Write-back: d_rdata is not modified; d_ready still pulses.
- Latency: req high in cycle 0 gives mem_req high from cycle 1. mem_ready in cycle 1+L gives ready in cycle 2+L. Minimum 3 cycles for L=0 (mem_ready in the first BUSY cycle).
- Throughput: with both requesters continuously active, grants strictly alternate. Neither side waits more than one foreign transaction.
- mem_ready outside BUSY: ignored, no state change.
- rdata registers hold their value between transactions.
- Reset mid-BUSY: mem_req drops immediately (async) and state returns to IDLE. The transaction is abandoned and no ready pulse is issued.
- A request arriving in the same cycle as the other side's ready is arbitrated in the next IDLE cycle, under normal round-robin rules.

Test Plan:
- Reset, memory model L=5, i_req with i_addr=0x0800, mem returns 0xDEADBEEF_0000_0001_0000_0002_0000_0003 -> i_ready in cycle 7 only, i_rdata equals that value, owner=0, mem_we=0.
- d_req with d_we=1, d_addr=0x3000, d_wdata=0x1234 -> mem_we=1, mem_addr=0x3000, mem_wdata=0x1234 held stable through BUSY; d_ready pulses once; d_rdata unchanged (0).
- i_req and d_req both raised in the same cycle after reset and held -> grants I, D, I, D with owner toggling each transaction; each ready 1 cycle wide.
- d_req held continuously, single i_req raised during a D transaction -> icache served next, before the second D.
- Spurious mem_ready in IDLE -> no ready pulse, busy stays 0.
- rst asserted 2 cycles into BUSY -> mem_req=0 in the same cycle, no i_ready/d_ready, icache wins the next tie.
